// File: rtl/i2s_tx_serializer.sv
// I2S / left-justified transmit serializer with a stereo-frame FIFO and fixed 32-cycle slots.
// Optional macro I2S_TX_UNDERRUN_REPEAT_EN: on underrun, resend the last popped frame instead of zeros.
module i2s_tx_serializer #(
    parameter int DEPTH = 4
) (
    input  logic        rclk,
    input  logic        rst,
    input  logic        en,
    input  logic        wen,
    input  logic [31:0] dinL,
    input  logic [31:0] dinR,
    input  logic        stereo,
    input  logic [1:0]  standard,
    input  logic [1:0]  word_size,
    output logic        sd,
    output logic        ws,
    output logic        full,
    output logic        empty,
    output logic        overflow,
    output logic        underrun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_reg;
    logic [63:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [AW:0] count_reg, count_next;
    logic        full_reg, empty_reg, overflow_reg, underrun_reg;
    logic [4:0]  cnt_reg;
    logic        ch_reg;
    logic [31:0] shadow_l_reg, shadow_r_reg;
    logic        stereo_reg, philips_reg;
    logic [1:0]  wsize_reg;
    logic        sd_reg, ws_reg, dly_reg;

    logic        running, frame_start, push, pop;
    logic [31:0] new_l, new_r, word;
    logic        eff_stereo, eff_philips;
    logic [1:0]  eff_wsize;
    logic [4:0]  wm1, idx;
    logic        lj_bit, sd_next;

    assign running     = (state_reg == RUN) && en;
    assign frame_start = running && (cnt_reg == 5'd0) && !ch_reg;
    assign push        = wen && !full_reg;
    assign pop         = frame_start && !empty_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (AW+1)'(1);
            2'b01:   count_next = count_reg - (AW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Source of the frame that starts this cycle: FIFO head, or the underrun fill.
    always_comb begin
        new_l = 32'd0;
        new_r = 32'd0;
        if (!empty_reg) begin
            {new_l, new_r} = mem[rd_ptr_reg];
        end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            new_l = shadow_l_reg;
            new_r = shadow_r_reg;
`else
            new_l = 32'd0;
            new_r = 32'd0;
`endif
        end
    end

    // At a frame start the live inputs apply; afterwards the latched copies do.
    always_comb begin
        eff_stereo  = frame_start ? stereo : stereo_reg;
        eff_philips = frame_start ? (standard == 2'b00) : philips_reg;
        eff_wsize   = frame_start ? word_size : wsize_reg;
        if (ch_reg)
            word = eff_stereo ? shadow_r_reg : shadow_l_reg;
        else
            word = frame_start ? new_l : shadow_l_reg;
        wm1     = {eff_wsize, 3'b111};
        idx     = wm1 - cnt_reg;
        lj_bit  = (cnt_reg <= wm1) ? word[idx] : 1'b0;
        sd_next = eff_philips ? dly_reg : lj_bit;
    end

    always_ff @(posedge rclk) begin
        if (push && !rst)
            mem[wr_ptr_reg] <= {dinL, dinR};
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            full_reg     <= 1'b0;
            empty_reg    <= 1'b1;
            overflow_reg <= 1'b0;
            underrun_reg <= 1'b0;
            cnt_reg      <= 5'd0;
            ch_reg       <= 1'b0;
            shadow_l_reg <= 32'd0;
            shadow_r_reg <= 32'd0;
            stereo_reg   <= 1'b0;
            philips_reg  <= 1'b0;
            wsize_reg    <= 2'b00;
            sd_reg       <= 1'b0;
            ws_reg       <= 1'b0;
            dly_reg      <= 1'b0;
        end else begin
            overflow_reg <= wen && full_reg;
            underrun_reg <= frame_start && empty_reg;
            count_reg    <= count_next;
            full_reg     <= (count_next == FULL_CNT);
            empty_reg    <= (count_next == '0);
            if (push)
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + AW'(1);

            case (state_reg)
                IDLE: begin
                    cnt_reg <= 5'd0;
                    ch_reg  <= 1'b0;
                    sd_reg  <= 1'b0;
                    ws_reg  <= 1'b0;
                    dly_reg <= 1'b0;
                    if (en)
                        state_reg <= RUN;
                end
                RUN: begin
                    if (!en) begin
                        state_reg <= IDLE;
                        cnt_reg   <= 5'd0;
                        ch_reg    <= 1'b0;
                        sd_reg    <= 1'b0;
                        ws_reg    <= 1'b0;
                        dly_reg   <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 5'd1;
                        if (cnt_reg == 5'd31)
                            ch_reg <= ~ch_reg;
                        sd_reg  <= sd_next;
                        ws_reg  <= ch_reg;
                        dly_reg <= lj_bit;
                        if (frame_start) begin
                            stereo_reg   <= stereo;
                            philips_reg  <= (standard == 2'b00);
                            wsize_reg    <= word_size;
                            shadow_l_reg <= new_l;
                            shadow_r_reg <= new_r;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign sd       = sd_reg;
    assign ws       = ws_reg;
    assign full     = full_reg;
    assign empty    = empty_reg;
    assign overflow = overflow_reg;
    assign underrun = underrun_reg;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Scoreboard bench for i2s_tx_serializer: expected {underrun,ws,sd} per output cycle is queued
// by the stimulus and popped by an independent monitor on the falling edge.
module tb_i2s_tx_serializer;

    logic        rclk = 1'b0;
    logic        rst, en, wen, stereo;
    logic [31:0] dinL, dinR;
    logic [1:0]  standard, word_size;
    logic        sd, ws, full, empty, overflow, underrun;

    always #5 rclk = ~rclk;

    i2s_tx_serializer #(.DEPTH(4)) dut (
        .rclk(rclk), .rst(rst), .en(en), .wen(wen),
        .dinL(dinL), .dinR(dinR), .stereo(stereo),
        .standard(standard), .word_size(word_size),
        .sd(sd), .ws(ws), .full(full), .empty(empty),
        .overflow(overflow), .underrun(underrun)
    );

    logic [2:0] exp_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    int  stream_idx = 0;
    bit  armed = 1'b0;
    bit  prev_lj = 1'b0;

    // Monitor: one comparison per serial output cycle while a stream is expected.
    always @(negedge rclk) begin
        if (armed && exp_q.size() > 0) begin
            logic [2:0] e;
            e = exp_q.pop_front();
            n_vec++;
            if ({underrun, ws, sd} !== e) begin
                n_err++;
                $display("FAIL stream[%0d]: {underrun,ws,sd} got %b required %b",
                         stream_idx, {underrun, ws, sd}, e);
            end
            stream_idx++;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h", name, got, req);
        end
    endtask

    // Expected 64 output cycles of one frame; Philips output is the left-justified bit one cycle late.
    function automatic void add_frame(input logic [31:0] l, input logic [31:0] r, input bit st,
                                      input bit ph, input logic [1:0] wsz, input bit un);
        int         w;
        logic [31:0] word;
        bit         lj, o;
        w = 8 * (int'(wsz) + 1);
        for (int c2 = 0; c2 < 2; c2++) begin
            for (int c = 0; c < 32; c++) begin
                word = (c2 == 1 && st) ? r : l;
                lj = (c < w) ? word[w-1-c] : 1'b0;
                o  = ph ? prev_lj : lj;
                prev_lj = lj;
                exp_q.push_back({(un && c2 == 0 && c == 0), (c2 == 1), o});
            end
        end
    endfunction

    task automatic push(input logic [31:0] l, input logic [31:0] r);
        @(posedge rclk); #1;
        wen = 1'b1; dinL = l; dinR = r;
        @(posedge rclk); #1;
        wen = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge rclk); #1;
        rst = 1'b1; en = 1'b0; wen = 1'b0;
        @(posedge rclk); #1;
        rst = 1'b0;
        prev_lj = 1'b0;
    endtask

    // Next rising edge enters RUN; first bit appears after the edge that follows.
    task automatic arm_and_wait(input bit chg);
        @(posedge rclk); #1;
        wen = 1'b0;
        @(posedge rclk);
        stream_idx = 0;
        armed = 1'b1;
        if (chg) begin
            #1;
            stereo = 1'b1; word_size = 2'b11; standard = 2'b00;
        end
        for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge rclk);
        armed = 1'b0;
        if (exp_q.size() != 0) begin
            n_vec++; n_err++;
            $display("FAIL stream_timeout: got %0d entries left required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic start_run(input bit chg);
        @(posedge rclk); #1;
        en = 1'b1;
        arm_and_wait(chg);
    endtask

    logic [31:0] fl [5];
    logic [31:0] fr [5];

    initial begin
        rst = 1'b1; en = 1'b0; wen = 1'b0; stereo = 1'b1;
        dinL = '0; dinR = '0; standard = 2'b01; word_size = 2'b11;
        repeat (2) @(posedge rclk);
        #1;
        check("reset_sd", 32'(sd), 32'd0);
        check("reset_ws", 32'(ws), 32'd0);
        check("reset_full", 32'(full), 32'd0);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_underrun", 32'(underrun), 32'd0);
        rst = 1'b0;

        // Left-justified, 32-bit, stereo.
        stereo = 1'b1; standard = 2'b01; word_size = 2'b11;
        push(32'hA5A5_0F0F, 32'h1234_5678);
        check("lj32_empty_after_push", 32'(empty), 32'd0);
        prev_lj = 1'b0;
        add_frame(32'hA5A5_0F0F, 32'h1234_5678, 1'b1, 1'b0, 2'b11, 1'b0);
        start_run(1'b0);
        do_reset();

        // Philips, 16-bit.
        stereo = 1'b1; standard = 2'b00; word_size = 2'b01;
        push(32'h0000_8001, 32'h0000_C003);
        add_frame(32'h0000_8001, 32'h0000_C003, 1'b1, 1'b1, 2'b01, 1'b0);
        start_run(1'b0);
        do_reset();

        // Mono 8-bit, with configuration changed mid-frame (must not take effect).
        stereo = 1'b0; standard = 2'b01; word_size = 2'b00;
        push(32'h0000_005A, 32'h0000_00FF);
        add_frame(32'h0000_005A, 32'h0000_00FF, 1'b0, 1'b0, 2'b00, 1'b0);
        start_run(1'b1);
        do_reset();

        // FIFO fill, overflow, in-order drain, then underrun.
        stereo = 1'b1; standard = 2'b01; word_size = 2'b01;
        fl[0] = 32'hDEAD_1234; fr[0] = 32'h0000_5678;
        fl[1] = 32'h0000_9ABC; fr[1] = 32'hBEEF_DEF0;
        fl[2] = 32'h0000_0FF0; fr[2] = 32'h0000_F00F;
        fl[3] = 32'h0000_8001; fr[3] = 32'h0000_7FFE;
        fl[4] = 32'h0000_FFFF; fr[4] = 32'h0000_FFFF;
        for (int i = 0; i < 5; i++) begin
            push(fl[i], fr[i]);
            check($sformatf("fifo_full_after_push%0d", i + 1), 32'(full), (i >= 3) ? 32'd1 : 32'd0);
            check($sformatf("fifo_overflow_after_push%0d", i + 1), 32'(overflow), (i == 4) ? 32'd1 : 32'd0);
        end
        @(posedge rclk); #1;
        check("overflow_single_pulse", 32'(overflow), 32'd0);
        check("full_after_overflow", 32'(full), 32'd1);
        for (int i = 0; i < 4; i++)
            add_frame(fl[i], fr[i], 1'b1, 1'b0, 2'b01, 1'b0);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        add_frame(fl[3], fr[3], 1'b1, 1'b0, 2'b01, 1'b1);
`else
        add_frame(32'd0, 32'd0, 1'b1, 1'b0, 2'b01, 1'b1);
`endif
        start_run(1'b0);
        do_reset();

        // Reset in the middle of a right slot, then restart cleanly.
        stereo = 1'b1; standard = 2'b01; word_size = 2'b11;
        push(32'hCAFE_F00D, 32'h0BAD_BEEF);
        @(posedge rclk); #1;
        en = 1'b1;
        @(posedge rclk);
        repeat (42) @(posedge rclk);
        #1;
        check("midframe_ws_right", 32'(ws), 32'd1);
        rst = 1'b1;
        @(posedge rclk); #1;
        check("midrst_sd", 32'(sd), 32'd0);
        check("midrst_ws", 32'(ws), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        rst = 1'b0; wen = 1'b1; dinL = 32'h8000_0001; dinR = 32'h0000_0003;
        prev_lj = 1'b0;
        add_frame(32'h8000_0001, 32'h0000_0003, 1'b1, 1'b0, 2'b11, 1'b0);
        arm_and_wait(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
